// File: rtl/instr_decode_stage_if.sv
// Handshake bundle between fetch, the decode stage and execute.
// Master is the fetch/execute side that drives the stage; slave is the stage itself.
interface instr_decode_stage_if #(
    parameter int PC_W = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_opcode;
    logic [PC_W-1:0] in_pc;
    logic            out_valid;
    logic            out_ready;
    logic [3:0]      out_class;
    logic            out_cond_pass;
    logic [31:0]     out_opcode;
    logic [PC_W-1:0] out_pc;
    logic [3:0]      out_rn;
    logic [3:0]      out_rd;
    logic [3:0]      out_rm;

    modport master (
        output in_valid, in_opcode, in_pc, out_ready,
        input  in_ready, out_valid, out_class, out_cond_pass,
               out_opcode, out_pc, out_rn, out_rd, out_rm
    );

    modport slave (
        input  in_valid, in_opcode, in_pc, out_ready,
        output in_ready, out_valid, out_class, out_cond_pass,
               out_opcode, out_pc, out_rn, out_rd, out_rm
    );
endinterface

// File: rtl/instr_decode_stage.sv
// ARM decode stage: classifies opcodes, evaluates the condition against NZCV
// at accept time and buffers the results in a small FIFO ahead of execute.
module instr_decode_stage #(
    parameter int PC_W    = 32,
    parameter int DEPTH   = 2,
    parameter bit COND_EN = 1'b1
) (
    input  logic                 CLK,
    input  logic                 nRESET,
    input  logic                 flush,
    input  logic [3:0]           flags,
    instr_decode_stage_if.slave  bus
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [3:0]      r_class    [DEPTH];
    logic            r_condPass [DEPTH];
    logic [31:0]     r_opcode   [DEPTH];
    logic [PC_W-1:0] r_pc       [DEPTH];

    logic [PTR_W-1:0] r_wrPtr;
    logic [PTR_W-1:0] r_rdPtr;
    logic [CNT_W-1:0] r_count;

    logic [3:0]  w_class;
    logic        w_condRaw;
    logic        w_condPass;
    logic        w_full;
    logic        w_empty;
    logic        w_push;
    logic        w_pop;
    logic [31:0] w_op;
    logic        w_n, w_z, w_c, w_v;

    assign w_op = bus.in_opcode;
    assign {w_n, w_z, w_c, w_v} = flags;

    always_comb begin
        w_class = 4'd7;
        case (w_op[27:26])
            2'b11: w_class = (w_op[25:24] == 2'b11) ? 4'd12 : 4'd13;
            2'b10: w_class = w_op[25] ? 4'd10 : 4'd9;
            2'b01: w_class = (w_op[25] && w_op[4]) ? 4'd0 : 4'd8;
            default: begin
                // Multiply/swap/halfword space sits inside data processing when bits 7 and 4 are set
                if (!w_op[25] && w_op[7] && w_op[4]) begin
                    if (w_op[6:5] == 2'b00 && w_op[24] && !w_op[23] &&
                        w_op[21:20] == 2'b00 && w_op[11:8] == 4'd0)
                        w_class = 4'd3;
                    else if (w_op[6:5] == 2'b00 && w_op[24:23] == 2'b00)
                        w_class = 4'd1;
                    else if (w_op[6:5] == 2'b00 && w_op[24:23] == 2'b01)
                        w_class = 4'd2;
                    else if (w_op[6:5] == 2'b01)
                        w_class = w_op[22] ? 4'd5 : 4'd4;
                    else if (w_op[6])
                        w_class = 4'd6;
                    else
                        w_class = 4'd0;
                end else begin
                    w_class = w_op[25] ? 4'd11 : 4'd7;
                end
            end
        endcase
    end

    always_comb begin
        w_condRaw = 1'b0;
        case (w_op[31:28])
            4'h0: w_condRaw = w_z;
            4'h1: w_condRaw = !w_z;
            4'h2: w_condRaw = w_c;
            4'h3: w_condRaw = !w_c;
            4'h4: w_condRaw = w_n;
            4'h5: w_condRaw = !w_n;
            4'h6: w_condRaw = w_v;
            4'h7: w_condRaw = !w_v;
            4'h8: w_condRaw = w_c && !w_z;
            4'h9: w_condRaw = !w_c || w_z;
            4'hA: w_condRaw = (w_n == w_v);
            4'hB: w_condRaw = (w_n != w_v);
            4'hC: w_condRaw = !w_z && (w_n == w_v);
            4'hD: w_condRaw = w_z || (w_n != w_v);
            4'hE: w_condRaw = 1'b1;
            default: w_condRaw = 1'b0;
        endcase
    end

    assign w_condPass = COND_EN ? w_condRaw : 1'b1;

    // Ready comes from the registered count only, so a full FIFO never passes through
    assign w_full  = (r_count == CNT_W'(DEPTH));
    assign w_empty = (r_count == '0);
    assign w_push  = bus.in_valid && !w_full && !flush;
    assign w_pop   = !w_empty && bus.out_ready && !flush;

    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else if (flush) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_push)
                r_wrPtr <= r_wrPtr + PTR_W'(1);
            if (w_pop)
                r_rdPtr <= r_rdPtr + PTR_W'(1);
            r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
        end
    end

    always_ff @(posedge CLK) begin
        if (w_push) begin
            r_class[r_wrPtr]    <= w_class;
            r_condPass[r_wrPtr] <= w_condPass;
            r_opcode[r_wrPtr]   <= bus.in_opcode;
            r_pc[r_wrPtr]       <= bus.in_pc;
        end
    end

    // Stale storage is never cleared; the empty mask keeps it off the outputs
    assign bus.in_ready      = !w_full;
    assign bus.out_valid     = !w_empty;
    assign bus.out_class     = w_empty ? 4'd0  : r_class[r_rdPtr];
    assign bus.out_cond_pass = w_empty ? 1'b0  : r_condPass[r_rdPtr];
    assign bus.out_opcode    = w_empty ? 32'd0 : r_opcode[r_rdPtr];
    assign bus.out_pc        = w_empty ? '0    : r_pc[r_rdPtr];
    assign bus.out_rn        = w_empty ? 4'd0  : r_opcode[r_rdPtr][19:16];
    assign bus.out_rd        = w_empty ? 4'd0  : r_opcode[r_rdPtr][15:12];
    assign bus.out_rm        = w_empty ? 4'd0  : r_opcode[r_rdPtr][3:0];
endmodule

// File: tb/tb_instr_decode_stage.sv
// Scoreboard bench for instr_decode_stage: directed cases then random traffic,
// with a second instance (condition evaluation disabled) run in lockstep.
module tb_instr_decode_stage;
    localparam int PC_W  = 32;
    localparam int DEPTH = 2;

    typedef struct {
        logic [31:0]     op;
        logic [PC_W-1:0] pc;
        logic [3:0]      cls;
        logic            pass;
    } exp_t;

    logic            CLK    = 1'b0;
    logic            nRESET = 1'b0;
    logic            flush  = 1'b0;
    logic [3:0]      flags  = 4'd0;
    logic [PC_W-1:0] pcCounter = '0;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    bit   modelReady = 1'b1;

    instr_decode_stage_if #(.PC_W(PC_W)) ifc0 ();
    instr_decode_stage_if #(.PC_W(PC_W)) ifc1 ();

    assign ifc1.in_valid  = ifc0.in_valid;
    assign ifc1.in_opcode = ifc0.in_opcode;
    assign ifc1.in_pc     = ifc0.in_pc;
    assign ifc1.out_ready = ifc0.out_ready;

    instr_decode_stage #(.PC_W(PC_W), .DEPTH(DEPTH), .COND_EN(1'b1)) dut (
        .CLK(CLK), .nRESET(nRESET), .flush(flush), .flags(flags), .bus(ifc0.slave)
    );

    instr_decode_stage #(.PC_W(PC_W), .DEPTH(DEPTH), .COND_EN(1'b0)) dutNoCond (
        .CLK(CLK), .nRESET(nRESET), .flush(flush), .flags(flags), .bus(ifc1.slave)
    );

    always #5 CLK = ~CLK;

    function automatic void checkOutput(string name, logic [95:0] act, logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Class table written as a decision list over opcode fields
    function automatic logic [3:0] refClass(logic [31:0] op);
        int  grp = int'(op[27:26]);
        bit  imm = op[25];
        int  sh  = int'(op[6:5]);
        if (grp == 3) return (op[25:24] == 2'b11) ? 4'd12 : 4'd13;
        if (grp == 2) return imm ? 4'd10 : 4'd9;
        if (grp == 1) return (imm && op[4]) ? 4'd0 : 4'd8;
        if (imm) return 4'd11;
        if (!(op[7] && op[4])) return 4'd7;
        if (sh == 0) begin
            if (op[24:23] == 2'b10 && op[21:20] == 2'b00 && op[11:8] == 4'd0) return 4'd3;
            if (op[24:23] == 2'b00) return 4'd1;
            if (op[24:23] == 2'b01) return 4'd2;
            return 4'd0;
        end
        if (sh == 1) return op[22] ? 4'd5 : 4'd4;
        return 4'd6;
    endfunction

    function automatic logic refCond(logic [3:0] cond, logic [3:0] f);
        bit n = f[3], z = f[2], c = f[1], v = f[0];
        case (cond)
            4'h0: return z;
            4'h1: return !z;
            4'h2: return c;
            4'h3: return !c;
            4'h4: return n;
            4'h5: return !n;
            4'h6: return v;
            4'h7: return !v;
            4'h8: return c && !z;
            4'h9: return !c || z;
            4'hA: return n == v;
            4'hB: return n != v;
            4'hC: return !z && (n == v);
            4'hD: return z || (n != v);
            4'hE: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // Monitor: compares the presented head against the scoreboard, then retires it on a pop
    always @(negedge CLK) begin : monitorProc
        exp_t h;
        bit   haveHead;
        haveHead = (q.size() != 0);
        modelReady = (q.size() != DEPTH);
        checkOutput("in_ready", ifc0.in_ready, modelReady);
        checkOutput("out_valid", ifc0.out_valid, haveHead);
        checkOutput("out_valid_nocond", ifc1.out_valid, haveHead);
        if (haveHead) begin
            h = q[0];
            checkOutput("out_class", ifc0.out_class, h.cls);
            checkOutput("out_cond_pass", ifc0.out_cond_pass, h.pass);
            checkOutput("out_opcode", ifc0.out_opcode, h.op);
            checkOutput("out_pc", ifc0.out_pc, h.pc);
            checkOutput("out_rn", ifc0.out_rn, h.op[19:16]);
            checkOutput("out_rd", ifc0.out_rd, h.op[15:12]);
            checkOutput("out_rm", ifc0.out_rm, h.op[3:0]);
            checkOutput("class_nocond", ifc1.out_class, h.cls);
            checkOutput("cond_pass_nocond", ifc1.out_cond_pass, 1'b1);
            if (ifc0.out_ready && !flush && nRESET)
                void'(q.pop_front());
        end else begin
            checkOutput("idle_data_zero",
                {ifc0.out_class, ifc0.out_cond_pass, ifc0.out_opcode, ifc0.out_pc,
                 ifc0.out_rn, ifc0.out_rd, ifc0.out_rm}, '0);
        end
    end

    // Input observer: records what the stage should accept on the coming edge
    always @(negedge CLK) begin : observerProc
        exp_t e;
        #1;
        if (nRESET) begin
            if (flush) begin
                q.delete();
            end else if (ifc0.in_valid && modelReady) begin
                e.op   = ifc0.in_opcode;
                e.pc   = ifc0.in_pc;
                e.cls  = refClass(ifc0.in_opcode);
                e.pass = refCond(ifc0.in_opcode[31:28], flags);
                q.push_back(e);
            end
        end
    end

    task automatic applyStimulus(input logic [31:0] op, input logic [3:0] f);
        bit acc = 1'b0;
        ifc0.in_valid  = 1'b1;
        ifc0.in_opcode = op;
        ifc0.in_pc     = pcCounter;
        flags          = f;
        pcCounter      = pcCounter + 4;
        for (int t = 0; t < 50 && !acc; t++) begin
            if (t > 4) ifc0.out_ready = 1'b1;
            @(negedge CLK);
            acc = ifc0.in_ready;
            @(posedge CLK);
            #1;
        end
        if (!acc) checkOutput("accept_timeout", 1'b0, 1'b1);
        ifc0.in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        ifc0.in_valid = 1'b0;
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    function automatic logic [31:0] randOp();
        logic [31:0] op = $urandom;
        case ($urandom_range(0, 3))
            1: begin op[27:25] = 3'b000; op[7] = 1'b1; op[4] = 1'b1; end
            2: op[27:26] = 2'b00;
            3: begin op[27:23] = 5'b00010; op[21:20] = 2'b00; op[11:8] = 4'd0; op[7:4] = 4'b1001; end
            default: ;
        endcase
        return op;
    endfunction

    logic [31:0] streamOps [8] = '{32'hE0010392, 32'hE1020091, 32'hE1D100B2, 32'hE1D100D2,
                                   32'hEF000000, 32'hEE000000, 32'hE7F000F0, 32'hF0821003};

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        ifc0.in_valid  = 1'b0;
        ifc0.in_opcode = 32'd0;
        ifc0.in_pc     = '0;
        ifc0.out_ready = 1'b1;
        nRESET = 1'b0;
        repeat (3) @(posedge CLK);
        #1 nRESET = 1'b1;

        applyStimulus(32'hE0821003, 4'b0000);
        idle(3);

        applyStimulus(32'h0A000004, 4'b0000);
        applyStimulus(32'h0A000004, 4'b0100);
        idle(2);

        foreach (streamOps[i]) applyStimulus(streamOps[i], 4'b0000);
        idle(3);

        // Back-pressure: A carries Z=1 and must keep its pass while flags change behind it
        ifc0.out_ready = 1'b0;
        applyStimulus(32'h0A000004, 4'b0100);
        applyStimulus(32'hE0010392, 4'b0000);
        ifc0.in_valid  = 1'b1;
        ifc0.in_opcode = 32'hE1D100B2;
        repeat (3) begin
            @(posedge CLK);
            #1;
        end
        ifc0.out_ready = 1'b1;
        applyStimulus(32'hE1D100B2, 4'b0000);
        idle(4);

        // Flush with two entries buffered and a pending input
        ifc0.out_ready = 1'b0;
        applyStimulus(32'hE0821003, 4'b1111);
        applyStimulus(32'hE1020091, 4'b0000);
        ifc0.in_valid  = 1'b1;
        ifc0.in_opcode = 32'hEF000000;
        flush = 1'b1;
        @(posedge CLK);
        #1;
        flush = 1'b0;
        ifc0.in_valid  = 1'b0;
        ifc0.out_ready = 1'b1;
        idle(3);

        for (int i = 0; i < 400; i++) begin
            ifc0.out_ready = ($urandom_range(0, 3) != 0);
            if (i == 200) begin
                ifc0.out_ready = 1'b0;
                applyStimulus(randOp(), 4'($urandom));
                applyStimulus(randOp(), 4'($urandom));
                ifc0.in_valid  = 1'b1;
                ifc0.in_opcode = randOp();
                #2;
                nRESET = 1'b0;
                #1;
                checkOutput("async_reset_valid", ifc0.out_valid, 1'b0);
                checkOutput("async_reset_ready", ifc0.in_ready, 1'b1);
                q.delete();
                repeat (2) @(posedge CLK);
                #1;
                nRESET = 1'b1;
                ifc0.in_valid = 1'b0;
            end else if ($urandom_range(0, 40) == 0) begin
                ifc0.in_valid  = $urandom_range(0, 1) != 0;
                ifc0.in_opcode = randOp();
                flush = 1'b1;
                @(posedge CLK);
                #1;
                flush = 1'b0;
                ifc0.in_valid = 1'b0;
            end else if ($urandom_range(0, 4) != 0) begin
                applyStimulus(randOp(), 4'($urandom));
            end else begin
                idle(1);
            end
        end

        ifc0.out_ready = 1'b1;
        ifc0.in_valid  = 1'b0;
        for (int t = 0; t < 20 && q.size() != 0; t++) begin
            @(posedge CLK);
            #1;
        end
        checkOutput("drain_empty", q.size() == 0, 1'b1);
        idle(2);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
